// File: rtl/receiver.sv
// receiver: two-wire serial-to-parallel receiver with start/stop framing and error detection
module receiver #(
    parameter int MESSAGE_LENGTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sda,
    input  logic                      scl,
    output logic [MESSAGE_LENGTH-1:0] data,
    output logic                      valid,
    output logic                      busy,
    output logic                      error
);
    localparam int CW = $clog2(MESSAGE_LENGTH);
    typedef enum logic {IDLE, RECV} state_t;
    state_t                    state;
    logic                      sda_q, scl_q, sda_p, scl_p;
    logic [CW-1:0]             bit_cnt;
    logic [MESSAGE_LENGTH-1:0] shift, shift_nx;
    logic                      rise, start, stop, last;
    assign rise  = !scl_p && scl_q;
    assign start = scl_p && scl_q && sda_p && !sda_q;
    assign stop  = scl_p && scl_q && !sda_p && sda_q;
    assign last  = bit_cnt == CW'(MESSAGE_LENGTH - 1);
    always_comb begin
        shift_nx          = shift;
        shift_nx[bit_cnt] = sda_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_q   <= 1'b1;
            scl_q   <= 1'b1;
            sda_p   <= 1'b1;
            scl_p   <= 1'b1;
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b0;
        end else begin
            sda_q <= sda;
            scl_q <= scl;
            sda_p <= sda_q;
            scl_p <= scl_q;
            valid <= 1'b0;
            error <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state   <= RECV;
                    busy    <= 1'b1;
                    bit_cnt <= '0;
                    shift   <= '0;
                end
            end else if (start) begin
                error   <= 1'b1;
                bit_cnt <= '0;
                shift   <= '0;
            end else if (stop) begin
                error <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
            end else if (rise) begin
                shift <= shift_nx;
                if (last) begin
                    data  <= shift_nx;
                    valid <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: drives master-style sda/scl frames and checks receiver outputs against an event-schedule model
module tb_receiver;
    logic       clk = 1'b0, rst = 1'b1, sda = 1'b1, scl = 1'b1;
    logic [7:0] data;
    logic       valid, busy, error;

    receiver #(.MESSAGE_LENGTH(8)) dut (
        .clk(clk), .rst(rst), .sda(sda), .scl(scl),
        .data(data), .valid(valid), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0, vcnt = 0, ecnt = 0;
    bit checking = 0;

    typedef enum {EV_BEGIN, EV_DONE, EV_ERR, EV_RESTART, EV_RESET} ev_k;
    typedef struct {int at; ev_k k; logic [7:0] w;} ev_t;
    ev_t evq[$];

    logic [7:0] m_data = 8'h00;
    logic       m_busy = 1'b0, m_valid = 1'b0, m_error = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, a, e);
        end
    endtask

    // Protocol-level expectations: each frame event is due two edges after the master drives it.
    always @(negedge clk) if (checking) begin
        m_valid = 1'b0;
        m_error = 1'b0;
        while (evq.size() > 0 && evq[0].at <= cyc) begin
            ev_t e;
            e = evq.pop_front();
            case (e.k)
                EV_BEGIN:   m_busy = 1'b1;
                EV_DONE:    begin m_valid = 1'b1; m_data = e.w; m_busy = 1'b0; end
                EV_ERR:     begin m_error = 1'b1; m_busy = 1'b0; end
                EV_RESTART: m_error = 1'b1;
                EV_RESET:   begin m_busy = 1'b0; m_data = 8'h00; end
            endcase
        end
        chk("valid", {31'd0, valid}, {31'd0, m_valid});
        chk("error", {31'd0, error}, {31'd0, m_error});
        chk("busy",  {31'd0, busy},  {31'd0, m_busy});
        chk("data",  {24'd0, data},  {24'd0, m_data});
        if (valid === 1'b1) vcnt++;
        if (error === 1'b1) ecnt++;
    end

    task automatic push(input int at, input ev_k k, input logic [7:0] w);
        evq.push_back('{at, k, w});
    endtask

    task automatic drive(input logic s, input logic c);
        sda = s;
        scl = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1);
    endtask

    task automatic start_cond(input bit restart);
        push(cyc + 2, restart ? EV_RESTART : EV_BEGIN, 8'h00);
        drive(1'b0, 1'b1);
    endtask

    task automatic send_bits(input logic [7:0] w, input int n, input bit complete);
        for (int i = 0; i < n; i++) begin
            drive(w[i], 1'b0);
            if (complete && i == n - 1) push(cyc + 2, EV_DONE, w);
            drive(w[i], 1'b1);
        end
    endtask

    task automatic frame(input logic [7:0] w);
        start_cond(1'b0);
        send_bits(w, 8, 1'b1);
        drive(1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        checking = 1;
        drive(1'b1, 1'b1);
        rst = 1'b0;
        idle(3);
        chk("reset_data", {24'd0, data}, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);

        frame(8'hA5);
        idle(3);
        chk("a5_data", {24'd0, data}, 32'hA5);
        chk("a5_vcnt", vcnt, 1);
        chk("a5_ecnt", ecnt, 0);

        frame(8'h3C);
        frame(8'hC3);
        idle(3);
        chk("b2b_data", {24'd0, data}, 32'hC3);
        chk("b2b_vcnt", vcnt, 3);

        frame(8'h00);
        chk("zero_data", {24'd0, data}, 32'h00);
        frame(8'hFF);
        idle(3);
        chk("ff_data", {24'd0, data}, 32'hFF);
        chk("edge_vcnt", vcnt, 5);
        chk("edge_ecnt", ecnt, 0);

        start_cond(1'b0);
        send_bits(8'h01, 3, 1'b0);
        push(cyc + 2, EV_ERR, 8'h00);
        drive(1'b1, 1'b1);
        idle(3);
        chk("stop_ecnt", ecnt, 1);
        chk("stop_vcnt", vcnt, 5);
        chk("stop_data", {24'd0, data}, 32'hFF);
        chk("stop_busy", {31'd0, busy}, 32'h0);

        start_cond(1'b0);
        send_bits(8'h1B, 5, 1'b0);
        start_cond(1'b1);
        send_bits(8'h5A, 8, 1'b1);
        drive(1'b1, 1'b1);
        idle(3);
        chk("rs_ecnt", ecnt, 2);
        chk("rs_vcnt", vcnt, 6);
        chk("rs_data", {24'd0, data}, 32'h5A);

        start_cond(1'b0);
        send_bits(8'h05, 4, 1'b0);
        idle(0);
        chk("mid_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        push(cyc + 1, EV_RESET, 8'h00);
        drive(1'b1, 1'b1);
        rst = 1'b0;
        chk("rst_busy",  {31'd0, busy},  32'h0);
        chk("rst_valid", {31'd0, valid}, 32'h0);
        chk("rst_error", {31'd0, error}, 32'h0);
        chk("rst_data",  {24'd0, data},  32'h0);
        idle(2);
        frame(8'h81);
        idle(4);
        chk("post_data", {24'd0, data}, 32'h81);
        chk("post_vcnt", vcnt, 7);
        chk("post_ecnt", ecnt, 2);
        chk("evq_drained", evq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
